// File: rtl/sprite_compositor_if.sv
// -----------------------------------------------------------------------------
// sprite_compositor_if
// Shadow-bank write bus used by game logic to update sprite attributes.
//   wr_en   : write strobe, one sprite per cycle
//   wr_sel  : sprite index (values >= number of sprites are ignored by the slave)
//   wr_x    : sprite top-left column
//   wr_y    : sprite top-left row
//   wr_rgb  : sprite colour {r[1:0],g[1:0],b[1:0]}
//   wr_vis  : sprite visible
// Modports: master (game logic / bench drives), slave (compositor receives).
// -----------------------------------------------------------------------------
interface sprite_compositor_if;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [10:0] wr_x;
  logic [10:0] wr_y;
  logic [5:0]  wr_rgb;
  logic        wr_vis;

  modport master (
    output wr_en, wr_sel, wr_x, wr_y, wr_rgb, wr_vis
  );

  modport slave (
    input wr_en, wr_sel, wr_x, wr_y, wr_rgb, wr_vis
  );
endinterface

// File: rtl/sprite_compositor.sv
// -----------------------------------------------------------------------------
// sprite_compositor
// N-sprite registered pixel compositor placed between the VGA timing block and
// the pad mux. Sprite attributes are written into a shadow bank and copied to
// the live bank once per frame (x==0, y==COMMIT_Y) so the picture never tears.
// Sprite 0 has the highest priority; pixels with de=1 that no sprite hits get
// the background colour. Two-stage pipeline, latency 2 for pixels and syncs.
//
// Optional feature: define SPRITE_COLLISION_EN to enable the per-frame
// collision flag; otherwise collision is tied to 0.
//
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   x, y, de              current pixel position and display enable
//   hsync_in, vsync_in    syncs from the timing block
//   wr                    shadow write bus (sprite_compositor_if.slave)
//   r, g, b               2-bit colour channels to pads
//   hsync_out, vsync_out  syncs delayed by 2
//   de_out                de delayed by 2
//   frame_tick            one-cycle pulse after the commit cycle
//   collision             >=2 visible sprites overlapped on a de pixel last frame
// -----------------------------------------------------------------------------
module sprite_compositor #(
  parameter int unsigned N_SPR     = 4,
  parameter int unsigned SPR_W     = 16,
  parameter int unsigned SPR_H     = 16,
  parameter logic [5:0]  BKG_RGB   = 6'h3E,
  parameter int unsigned COMMIT_Y  = 480,
  parameter logic        SYNC_IDLE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [10:0]               x,
  input  logic [10:0]               y,
  input  logic                      de,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  sprite_compositor_if.slave        wr,
  output logic [1:0]                r,
  output logic [1:0]                g,
  output logic [1:0]                b,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      de_out,
  output logic                      frame_tick,
  output logic                      collision
);

  logic                    commit;
  logic [N_SPR-1:0]        hit_c;
  logic [N_SPR-1:0][5:0]   live_rgb;

  // Stage 1 registers
  logic [N_SPR-1:0]        hit_s1_reg;
  logic [N_SPR-1:0][5:0]   rgb_s1_reg;
  logic                    de_s1_reg;
  logic                    hs_s1_reg;
  logic                    vs_s1_reg;

  // Stage 2 registers
  logic [5:0]              pix_s2_reg;
  logic [5:0]              pix_next;
  logic                    de_s2_reg;
  logic                    hs_s2_reg;
  logic                    vs_s2_reg;
  logic                    frame_tick_reg;

  assign commit = (x == 11'd0) && (y == 11'(COMMIT_Y));

  // Per-sprite shadow/live attribute registers and hit test.
  for (genvar gi = 0; gi < N_SPR; gi++) begin : g_spr
    logic [10:0] shadow_x_reg, shadow_y_reg, live_x_reg, live_y_reg;
    logic [5:0]  shadow_rgb_reg, live_rgb_reg;
    logic        shadow_vis_reg, live_vis_reg;
    logic        sel;
    logic [11:0] px, py, sx, sy;

    // wr_sel values >= N_SPR never match any generated index, so they are dropped.
    assign sel = wr.wr_en && (wr.wr_sel == 3'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_x_reg   <= '0;
        shadow_y_reg   <= '0;
        shadow_rgb_reg <= '0;
        shadow_vis_reg <= 1'b0;
        live_x_reg     <= '0;
        live_y_reg     <= '0;
        live_rgb_reg   <= '0;
        live_vis_reg   <= 1'b0;
      end else begin
        // Commit copies the shadow value as it was before this edge, so a
        // write landing on the commit cycle only becomes live next frame.
        if (commit) begin
          live_x_reg   <= shadow_x_reg;
          live_y_reg   <= shadow_y_reg;
          live_rgb_reg <= shadow_rgb_reg;
          live_vis_reg <= shadow_vis_reg;
        end
        if (sel) begin
          shadow_x_reg   <= wr.wr_x;
          shadow_y_reg   <= wr.wr_y;
          shadow_rgb_reg <= wr.wr_rgb;
          shadow_vis_reg <= wr.wr_vis;
        end
      end
    end

    // 12-bit compare: sx+SPR_W cannot wrap, so edge sprites are clipped.
    assign px = {1'b0, x};
    assign py = {1'b0, y};
    assign sx = {1'b0, live_x_reg};
    assign sy = {1'b0, live_y_reg};

    assign hit_c[gi] = live_vis_reg &&
                       (px >= sx) && (px < sx + 12'(SPR_W)) &&
                       (py >= sy) && (py < sy + 12'(SPR_H));
    assign live_rgb[gi] = live_rgb_reg;
  end

  // Stage 1: capture hits, live colours and timing signals.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_s1_reg <= '0;
      rgb_s1_reg <= '0;
      de_s1_reg  <= 1'b0;
      hs_s1_reg  <= SYNC_IDLE;
      vs_s1_reg  <= SYNC_IDLE;
    end else begin
      hit_s1_reg <= hit_c;
      rgb_s1_reg <= live_rgb;
      de_s1_reg  <= de;
      hs_s1_reg  <= hsync_in;
      vs_s1_reg  <= vsync_in;
    end
  end

  // Priority mux: scanning from the highest index down leaves the lowest
  // set hit index as the winner.
  always_comb begin
    pix_next = BKG_RGB;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (hit_s1_reg[i]) pix_next = rgb_s1_reg[i];
    end
    if (!de_s1_reg) pix_next = 6'h00;
  end

  // Stage 2: output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_s2_reg     <= '0;
      de_s2_reg      <= 1'b0;
      hs_s2_reg      <= SYNC_IDLE;
      vs_s2_reg      <= SYNC_IDLE;
      frame_tick_reg <= 1'b0;
    end else begin
      pix_s2_reg     <= pix_next;
      de_s2_reg      <= de_s1_reg;
      hs_s2_reg      <= hs_s1_reg;
      vs_s2_reg      <= vs_s1_reg;
      frame_tick_reg <= commit;
    end
  end

  assign r          = pix_s2_reg[5:4];
  assign g          = pix_s2_reg[3:2];
  assign b          = pix_s2_reg[1:0];
  assign de_out     = de_s2_reg;
  assign hsync_out  = hs_s2_reg;
  assign vsync_out  = vs_s2_reg;
  assign frame_tick = frame_tick_reg;

`ifdef SPRITE_COLLISION_EN
  logic [3:0] hit_cnt;
  logic       multi_hit;
  logic       pending_reg;
  logic       collision_reg;

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < N_SPR; i++) begin
      hit_cnt = hit_cnt + 4'(hit_s1_reg[i]);
    end
  end

  assign multi_hit = de_s1_reg && (hit_cnt >= 4'd2);

  // The S1 condition of the commit cycle is folded into the reported value,
  // so no pixel from the closing frame is lost when pending clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg   <= 1'b0;
      collision_reg <= 1'b0;
    end else if (commit) begin
      collision_reg <= pending_reg | multi_hit;
      pending_reg   <= 1'b0;
    end else if (multi_hit) begin
      pending_reg   <= 1'b1;
    end
  end

  assign collision = collision_reg;
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// -----------------------------------------------------------------------------
// tb_sprite_compositor
// Self-checking bench for sprite_compositor. Drives arbitrary pixel positions
// (not a full raster) and compares every cycle against a frame-level reference
// model; a table of probe pixels with fixed expected colours covers the
// directed scenarios. Honours SPRITE_COLLISION_EN for the collision output.
// -----------------------------------------------------------------------------
module tb_sprite_compositor;
  localparam int         N_SPR    = 4;
  localparam int         COMMIT_Y = 480;
  localparam logic [5:0] BKG      = 6'h3E;
`ifdef SPRITE_COLLISION_EN
  localparam logic       COLL_EN  = 1'b1;
`else
  localparam logic       COLL_EN  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] x = '0, y = '0;
  logic        de = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [1:0]  r, g, b;
  logic        hsync_out, vsync_out, de_out, frame_tick, collision;

  always #5 clk = ~clk;

  sprite_compositor_if bus ();

  sprite_compositor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x),
    .y          (y),
    .de         (de),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .wr         (bus.slave),
    .r          (r),
    .g          (g),
    .b          (b),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .de_out     (de_out),
    .frame_tick (frame_tick),
    .collision  (collision)
  );

  // ---------------- reference model ----------------
  typedef struct { int sx; int sy; logic [5:0] rgb; logic vis; } spr_t;
  typedef struct packed { logic [5:0] rgb; logic de; logic hs; logic vs; } out_t;

  spr_t sh [N_SPR];
  spr_t lv [N_SPR];
  out_t d1, d2;          // pixel one and two cycles down the 2-cycle latency line
  logic exp_tick, exp_coll, pend;

  // write staged for the next step
  logic       p_we;
  int         p_sel, p_x, p_y;
  logic [5:0] p_rgb;
  logic       p_vis;

  int checks = 0;
  int errors = 0;

  typedef struct { int ph; int x; int y; logic de; logic [5:0] rgb; } vec_t;
  vec_t tbl [$];

  localparam out_t IDLE_OUT = '{rgb: 6'h00, de: 1'b0, hs: 1'b1, vs: 1'b1};

  function automatic bit covers(spr_t s, int px, int py);
    return s.vis && px >= s.sx && px < s.sx + 16 && py >= s.sy && py < s.sy + 16;
  endfunction

  function automatic logic [5:0] ref_rgb(int px, int py, logic pde);
    if (!pde) return 6'h00;
    for (int i = 0; i < N_SPR; i++) if (covers(lv[i], px, py)) return lv[i].rgb;
    return BKG;
  endfunction

  function automatic int ref_hits(int px, int py);
    int n = 0;
    for (int i = 0; i < N_SPR; i++) if (covers(lv[i], px, py)) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_SPR; i++) begin
      sh[i] = '{0, 0, 6'h00, 1'b0};
      lv[i] = '{0, 0, 6'h00, 1'b0};
    end
    d1 = IDLE_OUT; d2 = IDLE_OUT;
    exp_tick = 1'b0; exp_coll = 1'b0; pend = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic stage_wr(input int sel, input int wx, input int wy,
                          input logic [5:0] rgb, input logic vis);
    p_we = 1'b1; p_sel = sel; p_x = wx; p_y = wy; p_rgb = rgb; p_vis = vis;
  endtask

  // One pixel clock: drive at negedge, advance model at posedge, check at +1.
  task automatic step(input int px, input int py, input logic pde,
                      input logic phs, input logic pvs);
    out_t nw;
    logic cm, cond;
    @(negedge clk);
    x = 11'(px); y = 11'(py); de = pde; hsync_in = phs; vsync_in = pvs;
    bus.wr_en  = p_we;
    bus.wr_sel = 3'(p_sel);
    bus.wr_x   = 11'(p_x);
    bus.wr_y   = 11'(p_y);
    bus.wr_rgb = p_rgb;
    bus.wr_vis = p_vis;
    nw   = '{rgb: ref_rgb(px, py, pde), de: pde, hs: phs, vs: pvs};
    cond = pde && (ref_hits(px, py) >= 2);
    cm   = (px == 0) && (py == COMMIT_Y);
    @(posedge clk);
    if (cm) lv = sh;
    if (p_we && p_sel < N_SPR) sh[p_sel] = '{p_x, p_y, p_rgb, p_vis};
    d2 = d1;
    d1 = nw;
    exp_tick = cm;
    if (COLL_EN) begin
      if (cm) begin
        exp_coll = pend;
        pend = cond;
      end else begin
        pend = pend | cond;
      end
    end
    #1;
    p_we = 1'b0;
    chk("pixel", 32'({r, g, b, de_out, hsync_out, vsync_out}),
        32'({d2.rgb, d2.de, d2.hs, d2.vs}));
    chk("frame_tick", 32'(frame_tick), 32'(exp_tick));
    chk("collision", 32'(collision), 32'(exp_coll));
  endtask

  task automatic commit_step();
    step(0, COMMIT_Y, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("tick_pulse", 32'(frame_tick), 32'd1);
  endtask

  // Random pixels clustered around a focus point plus full-range ones, then a commit.
  task automatic frame(input int n, input int fx, input int fy);
    int px, py;
    for (int i = 0; i < n; i++) begin
      if (i % 4 == 0) begin
        px = $urandom_range(0, 799);
        py = $urandom_range(0, 524);
      end else begin
        px = fx + $urandom_range(0, 60) - 30;
        py = fy + $urandom_range(0, 60) - 30;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
      end
      if (px == 0 && py == COMMIT_Y) py = COMMIT_Y + 1;
      step(px, py, (px < 640 && py < 480), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    commit_step();
  endtask

  task automatic run_phase(input int ph);
    foreach (tbl[i]) begin
      if (tbl[i].ph == ph) begin
        step(tbl[i].x, tbl[i].y, tbl[i].de, 1'b1, 1'b0);
        step(700, 500, 1'b0, 1'b0, 1'b1);
        chk($sformatf("probe%0d(%0d,%0d)", ph, tbl[i].x, tbl[i].y),
            32'({r, g, b}), 32'(tbl[i].rgb));
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, 32'({r, g, b, de_out, hsync_out, vsync_out, frame_tick, collision}),
        32'({6'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
  endtask

  task automatic add(input int ph, input int px, input int py, input logic pde,
                     input logic [5:0] rgb);
    tbl.push_back('{ph, px, py, pde, rgb});
  endtask

  initial begin
    // phase 0: spr0 written, not yet committed
    add(0, 100, 100, 1, 6'h3E); add(0, 110, 110, 1, 6'h3E);
    // phase 1: spr0 live at (100,100) colour 30
    add(1, 100, 100, 1, 6'h30); add(1, 115, 115, 1, 6'h30); add(1, 116, 100, 1, 6'h3E);
    add(1, 100, 116, 1, 6'h3E); add(1, 99, 100, 1, 6'h3E);  add(1, 100, 100, 0, 6'h00);
    // phase 2: spr0 (200,200)=30 over spr1 (208,208)=0C
    add(2, 204, 204, 1, 6'h30); add(2, 210, 210, 1, 6'h30); add(2, 215, 207, 1, 6'h30);
    add(2, 220, 220, 1, 6'h0C); add(2, 216, 210, 1, 6'h0C); add(2, 224, 224, 1, 6'h3E);
    // phase 3: spr2 at (630,470)=15, clipped at the screen edge
    add(3, 630, 470, 1, 6'h15); add(3, 639, 479, 1, 6'h15); add(3, 635, 475, 1, 6'h15);
    add(3, 629, 475, 1, 6'h3E); add(3, 0, 0, 1, 6'h3E);     add(3, 5, 5, 1, 6'h3E);
    add(3, 5, 475, 1, 6'h3E);   add(3, 635, 5, 1, 6'h3E);   add(3, 640, 475, 0, 6'h00);
    // phase 4: commit-cycle write of spr3 not live yet; out-of-range write ignored
    add(4, 55, 55, 1, 6'h3E);   add(4, 300, 300, 1, 6'h3E);
    // phase 5: spr3 live one frame later
    add(5, 55, 55, 1, 6'h07);   add(5, 300, 300, 1, 6'h3E);
    // phase 6: after reset all sprites invisible
    add(6, 55, 55, 1, 6'h3E);   add(6, 639, 479, 1, 6'h3E); add(6, 204, 204, 1, 6'h3E);

    p_we = 1'b0; p_sel = 0; p_x = 0; p_y = 0; p_rgb = '0; p_vis = 1'b0;
    bus.wr_en = 1'b0; bus.wr_sel = '0; bus.wr_x = '0; bus.wr_y = '0;
    bus.wr_rgb = '0; bus.wr_vis = 1'b0;
    model_reset();

    #12 check_reset_outputs("reset_state");
    @(posedge clk); #1 rst_n = 1'b1;

    frame(150, 320, 240);
    frame(150, 320, 240);

    stage_wr(0, 100, 100, 6'h30, 1'b1);
    step(300, 20, 1'b1, 1'b1, 1'b1);
    run_phase(0);
    commit_step();
    run_phase(1);
    frame(200, 108, 108);

    stage_wr(0, 200, 200, 6'h30, 1'b1); step(10, 10, 1'b1, 1'b0, 1'b0);
    stage_wr(1, 208, 208, 6'h0C, 1'b1); step(11, 10, 1'b1, 1'b0, 1'b0);
    commit_step();
    run_phase(2);
    stage_wr(1, 400, 400, 6'h0C, 1'b1); step(12, 10, 1'b1, 1'b0, 1'b0);
    commit_step();
    chk("collision_set", 32'(collision), 32'(COLL_EN));
    frame(200, 210, 210);
    chk("collision_clear", 32'(collision), 32'd0);

    stage_wr(0, 0, 0, 6'h00, 1'b0);      step(20, 20, 1'b1, 1'b0, 1'b0);
    stage_wr(1, 0, 0, 6'h00, 1'b0);      step(21, 20, 1'b1, 1'b0, 1'b0);
    stage_wr(2, 630, 470, 6'h15, 1'b1);  step(22, 20, 1'b1, 1'b0, 1'b0);
    commit_step();
    run_phase(3);
    frame(200, 635, 475);

    stage_wr(4, 300, 300, 6'h3F, 1'b1);  step(30, 20, 1'b1, 1'b0, 1'b0);
    stage_wr(3, 50, 50, 6'h07, 1'b1);
    commit_step();
    run_phase(4);
    commit_step();
    run_phase(5);
    frame(150, 55, 55);

    // mid-frame asynchronous reset on line 300
    for (int i = 0; i < 20; i++) step(i * 4, 300, 1'b1, 1'b0, 1'b0);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk); #1 check_reset_outputs("reset_held");
    rst_n = 1'b1;
    for (int i = 20; i < 40; i++) step(i * 4, 300, 1'b1, 1'b0, 1'b0);
    commit_step();
    run_phase(6);
    frame(100, 320, 240);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
